// File: rtl/ifetch_buffer.sv
// ifetch_buffer: instruction fetch stage sitting behind the PC register.
// Takes one fetch address at a time from the PC stage, issues a single
// word request to instruction memory, and parks each returned instruction
// together with its full PC in a small FIFO that feeds decode.
// A redirect (flush) kills the FIFO contents and any in-flight fetch.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   pc_in/pc_valid    fetch address offered by the PC stage
//   pc_ready          address accepted this cycle (combinational)
//   flush             redirect; drops buffered and in-flight fetches
//   imem_req/addr     word request to memory (registered, addr word-aligned)
//   imem_gnt          memory accepted the request
//   imem_rvalid/rdata memory response
//   ifid_valid/ready  handshake towards decode
//   ifid_instr/pc     instruction and its PC (low address bits preserved)
//   fetch_stall       PC hold hint: transaction outstanding or FIFO full
//
// Optional build macro IFETCH_PERF_EN adds perf_fetched and
// perf_wait_cycles counters; with it undefined those ports do not exist.
//
// state | meaning
// IDLE  | no transaction; may accept a new fetch address
// REQ   | request presented to memory, waiting for grant
// WAIT  | granted, waiting for the response beat
// DRAIN | flushed after grant; swallow the one pending response beat

module ifetch_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pc_in,
   input  logic             pc_valid,
   output logic             pc_ready,
   input  logic             flush,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic             ifid_valid,
   input  logic             ifid_ready,
   output logic [WIDTH-1:0] ifid_instr,
   output logic [WIDTH-1:0] ifid_pc,
`ifdef IFETCH_PERF_EN
   output logic [31:0]      perf_fetched,
   output logic [31:0]      perf_wait_cycles,
`endif
   output logic             fetch_stall
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   addr_q, addr_d;
   logic               imem_req_q, imem_req_d;
   logic [WIDTH-1:0]   imem_addr_q, imem_addr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   fifo_pc_q [DEPTH];
   logic [WIDTH-1:0]   fifo_pc_d [DEPTH];
   logic [WIDTH-1:0]   fifo_instr_q [DEPTH];
   logic [WIDTH-1:0]   fifo_instr_d [DEPTH];
   logic               push;
   logic               pop;

   assign ifid_valid  = (count_q != '0) && !flush;
   assign ifid_instr  = fifo_instr_q[rd_ptr_q];
   assign ifid_pc     = fifo_pc_q[rd_ptr_q];
   assign imem_req    = imem_req_q;
   assign imem_addr   = imem_addr_q;
   assign fetch_stall = (state_q != ST_IDLE) || (count_q == FULL_CNT);
   assign pop         = ifid_valid && ifid_ready;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      pc_ready    = 1'b0;
      push        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Accepting only with a free slot reserves room for the
            // eventual push; nothing else can fill the FIFO meanwhile.
            pc_ready = (count_q < FULL_CNT) && !flush;
            if (pc_valid && pc_ready) begin
               addr_d  = pc_in;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (flush) begin
               state_d = imem_gnt ? ST_DRAIN : ST_IDLE;
            end else if (imem_gnt) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               push    = !flush;
               state_d = ST_IDLE;
            end else if (flush) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Only one beat is ever owed; once it arrives there is nothing
            // left for a concurrent flush to kill, so leave regardless.
            if (imem_rvalid) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      imem_req_d  = (state_d == ST_REQ);
      imem_addr_d = imem_addr_q;
      if (state_d == ST_REQ) begin
         imem_addr_d = {addr_d[WIDTH-1:2], 2'b00};
      end
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      fifo_pc_d    = fifo_pc_q;
      fifo_instr_d = fifo_instr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            fifo_pc_d[wr_ptr_q]    = addr_q;
            fifo_instr_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d               = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         imem_req_q   <= 1'b0;
         imem_addr_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         fifo_pc_q    <= '{default: '0};
         fifo_instr_q <= '{default: '0};
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         imem_req_q   <= imem_req_d;
         imem_addr_q  <= imem_addr_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         fifo_pc_q    <= fifo_pc_d;
         fifo_instr_q <= fifo_instr_d;
      end
   end

`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_wait_q, perf_wait_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q + (pop ? 32'd1 : 32'd0);
      perf_wait_d    = perf_wait_q + ((state_q != ST_IDLE) ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched_q <= '0;
         perf_wait_q    <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_wait_q    <= perf_wait_d;
      end
   end

   assign perf_fetched     = perf_fetched_q;
   assign perf_wait_cycles = perf_wait_q;
`endif

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
      !(push && (count_q == FULL_CNT)));

endmodule

// File: doc/ifetch_buffer.md
Name: ifetch_buffer

Overview:
- Instruction fetch stage, directly downstream of the program counter register.
- Accepts fetch addresses from the PC stage, issues word requests to instruction memory, and tracks one outstanding transaction.
- Buffers returned instructions with their PC in a small FIFO, which feeds decode over a valid/ready handshake.
- Handles redirect (flush) by discarding buffered and in-flight fetches.

Parameters:
- WIDTH, 32, address/data width in bits.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- pc_in  in  WIDTH  fetch address from PC stage
- pc_valid  in  1  pc_in valid
- pc_ready  out  1  address accepted this cycle
- flush  in  1  branch/jump redirect; kill all fetches
- imem_req  out  1  memory request
- imem_addr  out  WIDTH  word-aligned request address
- imem_gnt  in  1  request accepted by memory
- imem_rvalid  in  1  response data valid
- imem_rdata  in  WIDTH  response instruction
- ifid_valid  out  1  instruction available to decode
- ifid_ready  in  1  decode consumes
- ifid_instr  out  WIDTH  instruction
- ifid_pc  out  WIDTH  PC of ifid_instr
- fetch_stall  out  1  high when state != IDLE or FIFO full (PC hold hint)

Behaviour:
- Reset values:
  - State IDLE; FIFO empty; all pointers and count 0; addr_q 0.
  - Outputs: imem_req 0, imem_addr 0, ifid_valid 0, ifid_instr 0, ifid_pc 0.
  - pc_ready and fetch_stall are combinational.
- FSM states: IDLE, REQ, WAIT, DRAIN.
  - IDLE:
    - pc_ready = (count < DEPTH) && !flush.
    - On pc_valid && pc_ready: addr_q <= pc_in; go REQ.
  - REQ:
    - imem_req = 1; imem_addr = {addr_q[WIDTH-1:2], 2'b00}.
    - On imem_gnt: go WAIT.
    - On flush without gnt: go IDLE; the request is withdrawn and memory permits this.
    - On flush with gnt: go DRAIN.
  - WAIT:
    - On imem_rvalid && !flush: push {addr_q, imem_rdata}; go IDLE.
    - On flush && imem_rvalid: discard data; go IDLE.
    - On flush && !imem_rvalid: go DRAIN.
  - DRAIN:
    - Discard the next imem_rvalid beat, then go IDLE.
    - flush while in DRAIN: stay in DRAIN.
    - pc_ready = 0.
- Space reservation: a request is only accepted when count < DEPTH. Count cannot rise while the request is in flight, so a push never overflows. A push while full is a design bug; guard with an assertion.
- FIFO:
  - Circular buffer with read/write pointers of log2(DEPTH) bits; pointers wrap naturally.
  - Count runs 0..DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - ifid_valid = (count != 0) && !flush.
  - ifid_instr/ifid_pc come from the read entry.
  - Pop on ifid_valid && ifid_ready.
- Flush:
  - Takes priority over every other event that cycle.
  - Next cycle: FIFO empty, pointers and count 0.
  - No pop is counted in the flush cycle.
- Latency:
  - pc accept at cycle N → imem_req at N+1.
  - With gnt at N+1 and rvalid at N+2 → ifid_valid at N+3.
  - Peak throughput: 1 instruction per 3 cycles (single outstanding).
- Reset asserted mid-transaction: immediate return to reset values. Stale memory responses after reset are the memory's responsibility.
- Addresses: no misalignment trap here. Bits [1:0] are dropped on imem_addr but preserved on ifid_pc.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched [31:0] and perf_wait_cycles [31:0].
  - perf_fetched increments on each ifid_valid && ifid_ready.
  - perf_wait_cycles increments on each cycle in REQ, WAIT or DRAIN.
  - Both reset to 0, wrap modulo 2^32, and are not cleared by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Single fetch:
  - Stimulus: reset; pc_in=0x100, pc_valid=1 at N; gnt at N+1; rvalid with rdata=0x00500093 at N+2; ifid_ready=1.
  - Required: imem_addr=0x100 at N+1; ifid_valid=1, ifid_instr=0x00500093, ifid_pc=0x100 at N+3; FIFO empty at N+4.
- Backpressure/full:
  - Stimulus: ifid_ready=0; fetch 0x0, 0x4 (DEPTH=2).
  - Required: count=2; pc_ready=0 with pc_valid=1; fetch_stall=1. After ifid_ready=1, entries pop in order 0x0, 0x4 and pc_ready re-asserts.
- Flush in WAIT:
  - Stimulus: gnt at N+1; flush at N+2, no rvalid; rvalid at N+4.
  - Required: state DRAIN at N+3; beat at N+4 discarded; ifid_valid stays 0; pc_ready=1 at N+5.
- Flush with buffered data:
  - Stimulus: FIFO holds 2 entries; flush=1 with ifid_ready=1.
  - Required: ifid_valid=0 that cycle; count=0 next cycle; no pop accounted.
- Async reset mid-REQ:
  - Stimulus: rst low while imem_req=1.
  - Required: imem_req=0 and ifid_valid=0 immediately, without waiting for clk.
- IFETCH_PERF_EN:
  - Stimulus: 3 fetches, each gnt and rvalid delayed by 1 cycle.
  - Required: perf_fetched=3, perf_wait_cycles=9.
